// File: rtl/tick_gen.sv
// Multi-channel clock divider producing 50% duty squares and a one-cycle tick per period.
// Runtime divisor loading (div_wr/div_sel/div_data/div_pend) exists only when DIV_LOAD_EN is defined.
module tick_gen #(
    parameter int unsigned               NUM_CH   = 2,
    parameter int unsigned               CNT_W    = 24,
    parameter logic [NUM_CH*CNT_W-1:0]   DIV_INIT = {24'd2500000, 24'd5000}
) (
    input  logic                                          clk_5MHz,
    input  logic                                          reset,
    input  logic [NUM_CH-1:0]                             en,
    input  logic                                          sync_clr,
`ifdef DIV_LOAD_EN
    input  logic                                          div_wr,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] div_sel,
    input  logic [CNT_W-1:0]                              div_data,
    output logic [NUM_CH-1:0]                             div_pend,
`endif
    output logic [NUM_CH-1:0]                             sq,
    output logic [NUM_CH-1:0]                             tick
);

    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [CNT_W-1:0]  div_use [NUM_CH];
    logic [NUM_CH-1:0] sq_q, sq_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] zero_evt;

    // A divisor of 0 behaves as 1, so both reload a count of 0.
    function automatic logic [CNT_W-1:0] reload_of(input logic [CNT_W-1:0] d);
        return (d == '0) ? '0 : d - CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] init_div(input int unsigned c);
        return DIV_INIT[c*CNT_W +: CNT_W];
    endfunction

    always_comb begin
        zero_evt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            zero_evt[c] = en[c] && (cnt_q[c] == '0);
        end
    end

`ifdef DIV_LOAD_EN
    logic [CNT_W-1:0]  div_q  [NUM_CH];
    logic [CNT_W-1:0]  div_d  [NUM_CH];
    logic [CNT_W-1:0]  pval_q [NUM_CH];
    logic [CNT_W-1:0]  pval_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] wr_hit;
    logic [NUM_CH-1:0] apply;

    // A pending value is consumed before a same-cycle write refills it.
    always_comb begin
        wr_hit = '0;
        apply  = '0;
        pend_d = pend_q;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_hit[c]  = div_wr && (int'(div_sel) == c);
            apply[c]   = pend_q[c] && (sync_clr || zero_evt[c]);
            div_use[c] = apply[c] ? pval_q[c] : div_q[c];
            div_d[c]   = div_use[c];
            pval_d[c]  = wr_hit[c] ? div_data : pval_q[c];
            if (wr_hit[c]) begin
                pend_d[c] = 1'b1;
            end else if (apply[c]) begin
                pend_d[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_5MHz) begin
        if (reset) begin
            pend_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                div_q[c]  <= init_div(c);
                pval_q[c] <= init_div(c);
            end
        end else begin
            pend_q <= pend_d;
            for (int c = 0; c < NUM_CH; c++) begin
                div_q[c]  <= div_d[c];
                pval_q[c] <= pval_d[c];
            end
        end
    end

    assign div_pend = pend_q;
`else
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            div_use[c] = init_div(c);
        end
    end
`endif

    always_comb begin
        sq_d   = sq_q;
        tick_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_d[c] = cnt_q[c];
            if (sync_clr) begin
                cnt_d[c] = reload_of(div_use[c]);
                sq_d[c]  = 1'b0;
            end else if (zero_evt[c]) begin
                cnt_d[c]  = reload_of(div_use[c]);
                sq_d[c]   = ~sq_q[c];
                tick_d[c] = ~sq_q[c];
            end else if (en[c]) begin
                cnt_d[c] = cnt_q[c] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_5MHz) begin
        if (reset) begin
            sq_q   <= '0;
            tick_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= reload_of(init_div(c));
            end
        end else begin
            sq_q   <= sq_d;
            tick_q <= tick_d;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign sq   = sq_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen: a cycles-to-next-toggle model queues expected outputs,
// a monitor compares them each cycle. Divisor-load checks build when DIV_LOAD_EN is defined.
module tb_tick_gen;
    localparam int unsigned NUM_CH = 2;
    localparam int unsigned CNT_W  = 8;
    localparam logic [NUM_CH*CNT_W-1:0] DIV_INIT = {8'd2, 8'd3};

    logic              clk_5MHz = 1'b0;
    logic              reset;
    logic              sync_clr;
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] sq;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pend_now;
`ifdef DIV_LOAD_EN
    logic              div_wr;
    logic [0:0]        div_sel;
    logic [CNT_W-1:0]  div_data;
    logic [NUM_CH-1:0] div_pend;
    assign pend_now = div_pend;
`else
    assign pend_now = '0;
`endif

    always #5 clk_5MHz = ~clk_5MHz;

    tick_gen #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .DIV_INIT (DIV_INIT)
    ) dut (
        .clk_5MHz (clk_5MHz),
        .reset    (reset),
        .en       (en),
        .sync_clr (sync_clr),
`ifdef DIV_LOAD_EN
        .div_wr   (div_wr),
        .div_sel  (div_sel),
        .div_data (div_data),
        .div_pend (div_pend),
`endif
        .sq       (sq),
        .tick     (tick)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference: per channel, enabled cycles left until the next sq toggle.
    int                init_div [NUM_CH] = '{3, 2};
    int                m_div    [NUM_CH];
    int                m_rem    [NUM_CH];
    int                m_pval   [NUM_CH];
    bit [NUM_CH-1:0]   m_sq, m_tick, m_pend;
    logic [3*NUM_CH-1:0] exp_q [$];

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset) begin
                m_div[c]  = init_div[c];
                m_rem[c]  = eff(init_div[c]);
                m_sq[c]   = 1'b0;
                m_tick[c] = 1'b0;
                m_pend[c] = 1'b0;
            end else begin
                m_tick[c] = 1'b0;
                if (sync_clr) begin
                    if (m_pend[c]) begin
                        m_div[c]  = m_pval[c];
                        m_pend[c] = 1'b0;
                    end
                    m_rem[c] = eff(m_div[c]);
                    m_sq[c]  = 1'b0;
                end else if (en[c]) begin
                    m_rem[c]--;
                    if (m_rem[c] == 0) begin
                        if (m_pend[c]) begin
                            m_div[c]  = m_pval[c];
                            m_pend[c] = 1'b0;
                        end
                        m_rem[c]  = eff(m_div[c]);
                        m_sq[c]   = ~m_sq[c];
                        m_tick[c] = m_sq[c];
                    end
                end
`ifdef DIV_LOAD_EN
                if (div_wr && int'(div_sel) == c) begin
                    m_pval[c] = int'(div_data);
                    m_pend[c] = 1'b1;
                end
`endif
            end
        end
        exp_q.push_back({m_pend, m_tick, m_sq});
    endtask

    logic [3*NUM_CH-1:0] sb_exp, sb_got;

    initial begin
        forever begin
            @(posedge clk_5MHz);
            #1;
            n_chk++;
            sb_got = {pend_now, tick, sq};
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_empty t=%0t got pend/tick/sq=%b required an expectation", $time,
                         sb_got);
            end else begin
                sb_exp = exp_q.pop_front();
                if (sb_got !== sb_exp) begin
                    n_err++;
                    $display("FAIL sb_cycle t=%0t got pend/tick/sq=%b required %b", $time, sb_got,
                             sb_exp);
                end
            end
        end
    end

    task automatic step();
        model_step();
        @(posedge clk_5MHz);
        #2;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
        n_chk++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    // Expects reset just released with en=11: sq[1] rises on edge 2, sq[0] on edge 3.
    task automatic check_first_rise(input string tag);
        step();
        chk({tag, "_e1_sq"}, 8'(sq), 8'h0);
        step();
        chk({tag, "_e2_sq"}, 8'(sq), 8'h2);
        chk({tag, "_e2_tick"}, 8'(tick), 8'h2);
        step();
        chk({tag, "_e3_sq"}, 8'(sq), 8'h3);
        chk({tag, "_e3_tick"}, 8'(tick), 8'h1);
    endtask

    initial begin
        reset    = 1'b1;
        sync_clr = 1'b1;
        en       = '1;
`ifdef DIV_LOAD_EN
        div_wr   = 1'b1;
        div_sel  = 1'b1;
        div_data = 8'd7;
`endif
        repeat (3) step();
        chk("reset_sq", 8'(sq), 8'h0);
        chk("reset_tick", 8'(tick), 8'h0);
        chk("reset_pend", 8'(pend_now), 8'h0);

        reset    = 1'b0;
        sync_clr = 1'b0;
`ifdef DIV_LOAD_EN
        div_wr   = 1'b0;
`endif
        check_first_rise("boot");
        repeat (13) step();

        en = 2'b10;
        repeat (5) step();
        chk("freeze_tick0", 8'(tick[0]), 8'h0);
        en = 2'b11;
        repeat (12) step();

        sync_clr = 1'b1;
        step();
        chk("sync_sq", 8'(sq), 8'h0);
        chk("sync_tick", 8'(tick), 8'h0);
        sync_clr = 1'b0;
        repeat (10) step();

`ifdef DIV_LOAD_EN
        step();
        div_wr   = 1'b1;
        div_sel  = 1'b1;
        div_data = 8'd5;
        step();
        div_wr = 1'b0;
        chk("pend_set", 8'(div_pend[1]), 8'h1);
        repeat (30) step();
        chk("pend_applied", 8'(div_pend[1]), 8'h0);

        div_wr   = 1'b1;
        div_sel  = 1'b0;
        div_data = 8'd0;
        step();
        div_wr = 1'b0;
        repeat (12) step();

        reset    = 1'b1;
        sync_clr = 1'b1;
        div_wr   = 1'b1;
        div_sel  = 1'b1;
        div_data = 8'd4;
        step();
        chk("rst2_sq", 8'(sq), 8'h0);
        chk("rst2_tick", 8'(tick), 8'h0);
        chk("rst2_pend", 8'(div_pend), 8'h0);
        reset    = 1'b0;
        sync_clr = 1'b0;
        div_wr   = 1'b0;
        check_first_rise("rst2");
`endif

        repeat (400) begin
            reset    = ($urandom_range(0, 99) == 0);
            sync_clr = ($urandom_range(0, 29) == 0);
            en       = 2'($urandom_range(0, 3));
`ifdef DIV_LOAD_EN
            div_wr   = ($urandom_range(0, 9) == 0);
            div_sel  = 1'($urandom_range(0, 1));
            div_data = 8'($urandom_range(0, 6));
`endif
            step();
        end

        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drained: got %0d queued required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
